matrix_store_writer: RTL



---
 rtl/matrix_store_writer_if.sv | 35 +++
 rtl/matrix_store_writer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_store_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_store_writer_if
//  Description : Write-request / payload handshake between the compute-side
//                initiator (master) and the matrix store writer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_store_writer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  write_request;
    logic                  write_ready;
    logic [2:0]            write_matrix_id;
    logic [7:0]            write_rows;
    logic [7:0]            write_cols;
    logic [0:7][7:0]       write_name;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_data_valid;
    logic                  writer_ready;
    logic                  write_done;
    logic                  write_error;

    modport master (
        output write_request, write_matrix_id, write_rows, write_cols,
               write_name, write_data, write_data_valid,
        input  write_ready, writer_ready, write_done, write_error
    );

    modport slave (
        input  write_request, write_matrix_id, write_rows, write_cols,
               write_name, write_data, write_data_valid,
        output write_ready, writer_ready, write_done, write_error
    );
endinterface
`default_nettype wire

// File: rtl/matrix_store_writer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_store_writer
//  Description : Validates a matrix store request, writes a 3-word header and
//                the row-major payload into the slot's BRAM block, and keeps
//                per-slot valid flags. Define MATRIX_STORE_ZERO_FILL_EN to
//                zero the unused tail of the slot after the payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_store_writer #(
    parameter int BLOCK_SIZE   = 1152,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int MATRIX_COUNT = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    matrix_store_writer_if.slave         wr,
    output logic                         bram_wr_en,
    output logic [ADDR_WIDTH-1:0]        bram_wr_addr,
    output logic [DATA_WIDTH-1:0]        bram_wr_data,
    output logic [MATRIX_COUNT-1:0]      matrix_valid
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CHECK = 4'd1,
        S_HDR0  = 4'd2,
        S_HDR1  = 4'd3,
        S_HDR2  = 4'd4,
        S_DATA  = 4'd5,
        S_FILL  = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    // Payload capacity of a slot once the header has been placed.
    localparam logic [15:0] c_MAX_TOTAL = 16'(BLOCK_SIZE - 3);
`ifdef MATRIX_STORE_ZERO_FILL_EN
    localparam logic [15:0] c_FILL_LAST = 16'(BLOCK_SIZE - 4);
`endif

    state_t                  state_q, state_d;
    logic [2:0]              id_q, id_d;
    logic [7:0]              rows_q, rows_d;
    logic [7:0]              cols_q, cols_d;
    logic [0:7][7:0]         name_q, name_d;
    logic [15:0]             k_q, k_d;
    logic                    write_done_q, write_done_d;
    logic                    write_error_q, write_error_d;
    logic                    bram_wr_en_q, bram_wr_en_d;
    logic [ADDR_WIDTH-1:0]   bram_wr_addr_q, bram_wr_addr_d;
    logic [DATA_WIDTH-1:0]   bram_wr_data_q, bram_wr_data_d;
    logic [MATRIX_COUNT-1:0] matrix_valid_q, matrix_valid_d;

    logic [15:0]             w_total;
    logic [31:0]             w_id_ext;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [ADDR_WIDTH-1:0]   w_data_addr;
    logic                    w_reject;

    assign w_total     = 16'(rows_q) * 16'(cols_q);
    assign w_id_ext    = 32'(id_q);
    assign w_base      = ADDR_WIDTH'(w_id_ext * 32'(BLOCK_SIZE));
    assign w_data_addr = w_base + ADDR_WIDTH'(k_q) + ADDR_WIDTH'(3);
    assign w_reject    = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                         (w_id_ext >= 32'(MATRIX_COUNT)) ||
                         (w_total > c_MAX_TOTAL);

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        rows_d         = rows_q;
        cols_d         = cols_q;
        name_d         = name_q;
        k_d            = k_q;
        write_done_d   = 1'b0;
        write_error_d  = 1'b0;
        bram_wr_en_d   = 1'b0;
        bram_wr_addr_d = bram_wr_addr_q;
        bram_wr_data_d = bram_wr_data_q;
        matrix_valid_d = matrix_valid_q;

        case (state_q)
            S_IDLE: begin
                k_d = 16'd0;
                if (wr.write_request) begin
                    id_d    = wr.write_matrix_id;
                    rows_d  = wr.write_rows;
                    cols_d  = wr.write_cols;
                    name_d  = wr.write_name;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_reject) begin
                    write_done_d  = 1'b1;
                    write_error_d = 1'b1;
                    state_d       = S_ERR;
                end else begin
                    // Readers must not see a slot while it is being rewritten.
                    matrix_valid_d[id_q] = 1'b0;
                    bram_wr_en_d         = 1'b1;
                    bram_wr_addr_d       = w_base;
                    bram_wr_data_d       = DATA_WIDTH'({16'h0, rows_q, cols_q});
                    state_d              = S_HDR0;
                end
            end
            S_HDR0: begin
                bram_wr_en_d   = 1'b1;
                bram_wr_addr_d = w_base + ADDR_WIDTH'(1);
                bram_wr_data_d = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
                state_d        = S_HDR1;
            end
            S_HDR1: begin
                bram_wr_en_d   = 1'b1;
                bram_wr_addr_d = w_base + ADDR_WIDTH'(2);
                bram_wr_data_d = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
                state_d        = S_HDR2;
            end
            S_HDR2: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (wr.write_data_valid) begin
                    bram_wr_en_d   = 1'b1;
                    bram_wr_addr_d = w_data_addr;
                    bram_wr_data_d = wr.write_data;
                    k_d            = k_q + 16'd1;
                    if (k_q == w_total - 16'd1) begin
`ifdef MATRIX_STORE_ZERO_FILL_EN
                        if (w_total == c_MAX_TOTAL) begin
                            write_done_d = 1'b1;
                            state_d      = S_DONE;
                        end else begin
                            state_d      = S_FILL;
                        end
`else
                        write_done_d = 1'b1;
                        state_d      = S_DONE;
`endif
                    end
                end
            end
`ifdef MATRIX_STORE_ZERO_FILL_EN
            S_FILL: begin
                bram_wr_en_d   = 1'b1;
                bram_wr_addr_d = w_data_addr;
                bram_wr_data_d = '0;
                k_d            = k_q + 16'd1;
                if (k_q == c_FILL_LAST) begin
                    write_done_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
`endif
            S_DONE: begin
                matrix_valid_d[id_q] = 1'b1;
                state_d              = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            id_q           <= '0;
            rows_q         <= '0;
            cols_q         <= '0;
            name_q         <= '0;
            k_q            <= '0;
            write_done_q   <= 1'b0;
            write_error_q  <= 1'b0;
            bram_wr_en_q   <= 1'b0;
            bram_wr_addr_q <= '0;
            bram_wr_data_q <= '0;
            matrix_valid_q <= '0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            name_q         <= name_d;
            k_q            <= k_d;
            write_done_q   <= write_done_d;
            write_error_q  <= write_error_d;
            bram_wr_en_q   <= bram_wr_en_d;
            bram_wr_addr_q <= bram_wr_addr_d;
            bram_wr_data_q <= bram_wr_data_d;
            matrix_valid_q <= matrix_valid_d;
        end
    end

    assign wr.write_ready  = (state_q == S_IDLE);
    assign wr.writer_ready = (state_q == S_DATA);
    assign wr.write_done   = write_done_q;
    assign wr.write_error  = write_error_q;
    assign bram_wr_en      = bram_wr_en_q;
    assign bram_wr_addr    = bram_wr_addr_q;
    assign bram_wr_data    = bram_wr_data_q;
    assign matrix_valid    = matrix_valid_q;

endmodule
`default_nettype wire
